// File: rtl/sam_vcount_pkg.sv
// Shared constants for the SAM video address counter: register window,
// datapath widths and the display-mode geometry table.
package sam_vcount_pkg;

    localparam int ADDR_W = 15;
    localparam int OFF_W  = 7;
    localparam int MODE_W = 3;
    localparam int NREG   = MODE_W + OFF_W;

    localparam logic [15:0] REG_BASE = 16'hFFC0;
    localparam logic [15:0] REG_LAST = REG_BASE + 16'(2 * NREG - 1);

    typedef struct packed {
        logic [5:0] bpr;   // bytes per displayed row
        logic [3:0] ydiv;  // scan lines per displayed row
    } geom_t;

    function automatic geom_t mode_geom(input logic [MODE_W-1:0] m);
        geom_t g;
        case (m)
            3'b000:  g = '{bpr: 6'd32, ydiv: 4'd12};
            3'b001:  g = '{bpr: 6'd16, ydiv: 4'd3};
            3'b010:  g = '{bpr: 6'd32, ydiv: 4'd3};
            3'b011:  g = '{bpr: 6'd16, ydiv: 4'd2};
            3'b100:  g = '{bpr: 6'd32, ydiv: 4'd2};
            3'b101:  g = '{bpr: 6'd16, ydiv: 4'd1};
            default: g = '{bpr: 6'd32, ydiv: 4'd1};
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sam_vreg.sv
// SAM V/F register bank: even address in the window clears a bit, odd sets it.
module sam_vreg
    import sam_vcount_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [15:0]       wr_addr,
    output logic [MODE_W-1:0] mode,
    output logic [OFF_W-1:0]  offset
);

    logic [NREG-1:0] regs;
    logic [NREG-1:0] regs_next;
    logic [4:0]      idx;
    logic            hit;

    assign idx = 5'(wr_addr - REG_BASE);
    assign hit = wr && (wr_addr >= REG_BASE) && (wr_addr <= REG_LAST);

    always_comb begin
        regs_next = regs;
        if (hit) begin
            regs_next[idx[4:1]] = idx[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else begin
            regs <= regs_next;
        end
    end

    assign mode   = regs[MODE_W-1:0];
    assign offset = regs[NREG-1:MODE_W];

endmodule

// File: rtl/sam_vcount.sv
// SAM video address counter: row base / line-repeat tracking that drives the
// video-port address of the display RAM directly from a register.
module sam_vcount
    import sam_vcount_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [15:0]       wr_addr,
    input  logic              field_start,
    input  logic              line_start,
    input  logic              fetch,
    output logic [ADDR_W-1:0] vaddr,
    output logic [MODE_W-1:0] mode,
    output logic [OFF_W-1:0]  offset
);

    logic [ADDR_W-1:0] row_base, row_base_next;
    logic [ADDR_W-1:0] vaddr_next;
    logic [3:0]        rep, rep_next;
    logic              first_line, first_line_next;
    logic              armed, armed_next;

    geom_t             geom;
    logic [ADDR_W-1:0] field_base;
    logic [ADDR_W-1:0] row_sum;
    logic              last_rep;

    sam_vreg u_vreg (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .wr_addr (wr_addr),
        .mode    (mode),
        .offset  (offset)
    );

    // mode/offset seen here are the pre-write values when a wr coincides.
    assign geom       = mode_geom(mode);
    // Offset in 512-byte units; the top offset bit falls off the 32K space.
    assign field_base = {offset[OFF_W-2:0], 9'd0};
    assign row_sum    = row_base + ADDR_W'(geom.bpr);
    // ">=" also covers a mode switch that shrinks YDIV below the current rep.
    assign last_rep   = (rep >= (geom.ydiv - 4'd1));

    always_comb begin
        row_base_next   = row_base;
        vaddr_next      = vaddr;
        rep_next        = rep;
        first_line_next = first_line;
        armed_next      = armed;
        if (field_start) begin
            row_base_next   = field_base;
            vaddr_next      = field_base;
            rep_next        = 4'd0;
            first_line_next = 1'b1;
            armed_next      = 1'b1;
        end else if (armed && line_start) begin
            if (first_line) begin
                first_line_next = 1'b0;
                rep_next        = 4'd0;
                vaddr_next      = row_base;
            end else if (last_rep) begin
                rep_next      = 4'd0;
                row_base_next = row_sum;
                vaddr_next    = row_sum;
            end else begin
                rep_next   = rep + 4'd1;
                vaddr_next = row_base;
            end
        end else if (armed && fetch) begin
            vaddr_next = vaddr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base   <= '0;
            vaddr      <= '0;
            rep        <= 4'd0;
            first_line <= 1'b1;
            armed      <= 1'b0;
        end else begin
            row_base   <= row_base_next;
            vaddr      <= vaddr_next;
            rep        <= rep_next;
            first_line <= first_line_next;
            armed      <= armed_next;
        end
    end

endmodule
